// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, STATUS bit
// positions and the TX/RX state encodings.
package uart_pkg;

  localparam logic [2:0] REG_DATA   = 3'h0;
  localparam logic [2:0] REG_STATUS = 3'h4;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_TX_BUSY     = 2;
  localparam int ST_RX_VALID    = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_TX_OVERFLOW = 5;
  localparam int ST_FRAME_ERR   = 6;

  typedef logic [1:0] txState_t;
  localparam txState_t TX_IDLE  = 2'd0;
  localparam txState_t TX_START = 2'd1;
  localparam txState_t TX_DATA  = 2'd2;
  localparam txState_t TX_STOP  = 2'd3;

  typedef logic [1:0] rxState_t;
  localparam rxState_t RX_IDLE  = 2'd0;
  localparam rxState_t RX_START = 2'd1;
  localparam rxState_t RX_DATA  = 2'd2;
  localparam rxState_t RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO used as the UART transmit buffer. Push when full and
// pop when empty are ignored; simultaneous push and pop leave the count unchanged.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wrData,
  output logic [WIDTH-1:0]           rdData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_port.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers, TX FIFO feeding a serializer,
// and an oversampled receiver with a one-byte holding register.
//   state    | meaning
//   TX_IDLE  | line high, waiting for a FIFO entry
//   TX_START | driving start bit (0)
//   TX_DATA  | shifting 8 data bits, LSB first
//   TX_STOP  | driving stop bit (1); chains straight into the next frame
//   RX_IDLE  | waiting for a synchronized falling edge
//   RX_START | half-bit wait, then confirm the start bit
//   RX_DATA  | sampling 8 data bits at bit centres
//   RX_STOP  | sampling the stop bit
module uart_port import uart_pkg::*; #(
  parameter int CLK_DIV  = 104,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chipSelect,
  input  logic        regSelect,
  input  logic        writeEnable,
  input  logic        readStrobe,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        txd,
  input  logic        rxd
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  logic isStatus, dataWrite, statusWrite, dataRead;
  logic txFull, txEmpty, txPop, txBitDone, txBusy;
  logic [7:0] txHead;
  logic [TXCW-1:0] txCount;
  txState_t txState;
  logic [CW-1:0] txCnt;
  logic [2:0] txBitIdx;
  logic [7:0] txShift;

  logic [1:0] rxSync;
  logic rxLast, rxIn, rxFall, rxHalfDone, rxBitDone, rxStopSample, rxGood, rxBad;
  rxState_t rxState;
  logic [CW-1:0] rxCnt;
  logic [2:0] rxBitIdx;
  logic [7:0] rxShift;
  logic [7:0] rxByte;
  logic rxValid, rxOverrun, txOverflow, frameErr;
  logic unusedDataIn;

  assign isStatus     = (regSelect == REG_STATUS[2]);
  assign dataWrite    = chipSelect && !isStatus && writeEnable;
  assign statusWrite  = chipSelect && isStatus && writeEnable;
  assign dataRead     = chipSelect && !isStatus && readStrobe;
  assign unusedDataIn = ^dataIn[31:8];

  uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) txFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (dataWrite),
    .pop    (txPop),
    .wrData (dataIn[7:0]),
    .rdData (txHead),
    .full   (txFull),
    .empty  (txEmpty),
    .count  (txCount)
  );

  assign txBitDone = (txCnt == BIT_LAST);
  assign txBusy    = (txState != TX_IDLE);
  // Popping at the end of the stop bit keeps back-to-back frames gapless.
  assign txPop     = !txEmpty && ((txState == TX_IDLE) || (txState == TX_STOP && txBitDone));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState  <= TX_IDLE;
      txCnt    <= '0;
      txBitIdx <= '0;
      txShift  <= '0;
      txd      <= 1'b1;
    end else if (txPop) begin
      txState <= TX_START;
      txShift <= txHead;
      txCnt   <= '0;
      txd     <= 1'b0;
    end else begin
      case (txState)
        TX_START: begin
          if (txBitDone) begin
            txState  <= TX_DATA;
            txCnt    <= '0;
            txBitIdx <= '0;
            txd      <= txShift[0];
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (txBitDone) begin
            txCnt <= '0;
            if (txBitIdx == 3'd7) begin
              txState <= TX_STOP;
              txd     <= 1'b1;
            end else begin
              txShift  <= txShift >> 1;
              txd      <= txShift[1];
              txBitIdx <= txBitIdx + 1'b1;
            end
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (txBitDone) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
          end else begin
            txCnt <= txCnt + 1'b1;
          end
        end
        default: begin
          txState <= TX_IDLE;
          txCnt   <= '0;
          txd     <= 1'b1;
        end
      endcase
    end
  end

  assign rxIn         = rxSync[1];
  assign rxFall       = rxLast && !rxIn;
  assign rxHalfDone   = (rxCnt == HALF_LAST);
  assign rxBitDone    = (rxCnt == BIT_LAST);
  assign rxStopSample = (rxState == RX_STOP) && rxBitDone;
  assign rxGood       = rxStopSample && rxIn;
  assign rxBad        = rxStopSample && !rxIn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxSync   <= 2'b11;
      rxLast   <= 1'b1;
      rxState  <= RX_IDLE;
      rxCnt    <= '0;
      rxBitIdx <= '0;
      rxShift  <= '0;
    end else begin
      rxSync <= {rxSync[0], rxd};
      rxLast <= rxIn;
      case (rxState)
        RX_IDLE: begin
          if (rxFall) begin
            rxState <= RX_START;
            rxCnt   <= '0;
          end
        end
        RX_START: begin
          if (rxHalfDone) begin
            rxCnt    <= '0;
            rxBitIdx <= '0;
            rxState  <= rxIn ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rxBitDone) begin
            rxCnt   <= '0;
            rxShift <= {rxIn, rxShift[7:1]};
            if (rxBitIdx == 3'd7) rxState <= RX_STOP;
            else                  rxBitIdx <= rxBitIdx + 1'b1;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        default: begin
          if (rxBitDone) begin
            rxState <= RX_IDLE;
            rxCnt   <= '0;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a software clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxByte     <= '0;
      rxValid    <= 1'b0;
      rxOverrun  <= 1'b0;
      txOverflow <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      if (rxGood) rxByte <= rxShift;

      if (rxGood)        rxValid <= 1'b1;
      else if (dataRead) rxValid <= 1'b0;

      if (rxGood && rxValid && !dataRead)             rxOverrun <= 1'b1;
      else if (statusWrite && dataIn[ST_RX_OVERRUN])  rxOverrun <= 1'b0;

      if (dataWrite && txFull)                        txOverflow <= 1'b1;
      else if (statusWrite && dataIn[ST_TX_OVERFLOW]) txOverflow <= 1'b0;

      if (rxBad)                                      frameErr <= 1'b1;
      else if (statusWrite && dataIn[ST_FRAME_ERR])   frameErr <= 1'b0;
    end
  end

  always_comb begin
    dataOut = '0;
    if (chipSelect) begin
      if (isStatus) begin
        dataOut[ST_TX_FULL]     = txFull;
        dataOut[ST_TX_EMPTY]    = txEmpty;
        dataOut[ST_TX_BUSY]     = txBusy;
        dataOut[ST_RX_VALID]    = rxValid;
        dataOut[ST_RX_OVERRUN]  = rxOverrun;
        dataOut[ST_TX_OVERFLOW] = txOverflow;
        dataOut[ST_FRAME_ERR]   = frameErr;
      end else begin
        dataOut[7:0] = rxByte;
      end
    end
  end

  fifoCountBound: assert property (@(posedge clk) disable iff (!rst) txCount <= TXCW'(TX_DEPTH));

endmodule
